// File: rtl/pattern_det_ctrl_if.sv
// Bundles the configuration, run-control, serial-data and result signals of
// the pattern detector so the controller and its driver share one port list.
interface pattern_det_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    // configuration write channel
    logic                 cfg_valid_i;
    logic [MAX_LEN-1:0]   cfg_pat_i;
    logic [LEN_W-1:0]     cfg_len_i;
    logic                 cfg_ready_o;
    logic                 cfg_err_o;

    // run control
    logic [CNT_W-1:0]     bit_limit_i;
    logic                 start_i;
    logic                 stop_i;

    // serial data
    logic                 d_in;
    logic                 valid_i;

    // results / status
    logic                 pattern;
    logic [CNT_W-1:0]     match_count_o;
    logic                 busy_o;
    logic                 done_o;

    // driver side
    modport master (
        output cfg_valid_i, cfg_pat_i, cfg_len_i, bit_limit_i,
               start_i, stop_i, d_in, valid_i,
        input  cfg_ready_o, cfg_err_o, pattern, match_count_o, busy_o, done_o
    );

    // detector side
    modport slave (
        input  cfg_valid_i, cfg_pat_i, cfg_len_i, bit_limit_i,
               start_i, stop_i, d_in, valid_i,
        output cfg_ready_o, cfg_err_o, pattern, match_count_o, busy_o, done_o
    );
endinterface

// File: rtl/pattern_det_ctrl.sv
// Programmable serial pattern detector with a run controller.
// A pattern of 1..MAX_LEN bits is written while idle; a run then shifts the
// qualified serial stream into a history register, pulses 'pattern' one cycle
// after each completing bit and counts matches until stop or a bit limit.
module pattern_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    parameter int OVERLAP = 1
) (
    input  logic               clk,
    input  logic               rst,
    pattern_det_ctrl_if.slave  bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    // controller state
    state_t               state_q,     state_d;
    logic                 loaded_q,    loaded_d;

    // stored configuration
    logic [MAX_LEN-1:0]   pat_q,       pat_d;
    logic [LEN_W-1:0]     len_q,       len_d;
    logic [CNT_W-1:0]     limit_q,     limit_d;

    // run datapath
    logic [MAX_LEN-1:0]   hist_q,      hist_d;
    logic [LEN_W-1:0]     fill_q,      fill_d;
    logic [CNT_W-1:0]     bit_cnt_q,   bit_cnt_d;
    logic [CNT_W-1:0]     match_cnt_q, match_cnt_d;

    // registered outputs
    logic                 pattern_q,   pattern_d;
    logic                 cfg_err_q,   cfg_err_d;
    logic                 cfg_ready_q, cfg_ready_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;

    // helpers for the bit being presented this cycle
    logic [MAX_LEN-1:0]   len_mask;
    logic [MAX_LEN-1:0]   hist_shift;
    logic [LEN_W-1:0]     fill_inc;
    logic [CNT_W-1:0]     bit_inc;
    logic                 len_legal;
    logic                 hit;

    // Mask selecting the low len_q bits; only those take part in comparison.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
        assign len_mask[gi] = (LEN_W'(gi) < len_q);
    end

    // Match evaluation uses the history as it will look after this bit.
    always_comb begin
        hist_shift = (hist_q << 1) | MAX_LEN'(bus.d_in);
        fill_inc   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
        bit_inc    = bit_cnt_q + CNT_W'(1);
        len_legal  = (bus.cfg_len_i != '0) && (bus.cfg_len_i <= LEN_W'(MAX_LEN));
        hit        = (fill_inc >= len_q) &&
                     ((hist_shift & len_mask) == (pat_q & len_mask));
    end

    // Next-state logic for the controller, configuration store and datapath.
    always_comb begin
        state_d     = state_q;
        loaded_d    = loaded_q;
        pat_d       = pat_q;
        len_d       = len_q;
        limit_d     = limit_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        bit_cnt_d   = bit_cnt_q;
        match_cnt_d = match_cnt_q;
        pattern_d   = 1'b0;
        cfg_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Config writes are only honoured while idle; an illegal
                // length keeps the old config and just flags the error.
                if (bus.cfg_valid_i) begin
                    if (len_legal) begin
                        pat_d    = bus.cfg_pat_i;
                        len_d    = bus.cfg_len_i;
                        loaded_d = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                // A run needs a config that was loaded before this cycle.
                if (bus.start_i && loaded_q) begin
                    state_d     = ARMED;
                    hist_d      = '0;
                    fill_d      = '0;
                    bit_cnt_d   = '0;
                    match_cnt_d = '0;
                    limit_d     = bus.bit_limit_i;
                end
            end

            ARMED: begin
                if (bus.valid_i) begin
                    hist_d    = hist_shift;
                    fill_d    = fill_inc;
                    bit_cnt_d = bit_inc;
                    if (hit) begin
                        pattern_d = 1'b1;
                        if (match_cnt_q != {CNT_W{1'b1}}) begin
                            match_cnt_d = match_cnt_q + CNT_W'(1);
                        end
                        // Non-overlapping mode: the next match must be built
                        // entirely from bits received after this one.
                        if (OVERLAP == 0) begin
                            fill_d = '0;
                        end
                    end
                    // The limiting bit itself has just been evaluated above.
                    if ((limit_q != '0) && (bit_inc == limit_q)) begin
                        state_d = DONE;
                    end
                end
                if (bus.stop_i) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are decoded from the next state so they are
        // registered and line up exactly with the state they describe.
        cfg_ready_d = (state_d == IDLE);
        busy_d      = (state_d == ARMED);
        done_d      = (state_d == DONE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            loaded_q    <= 1'b0;
            pat_q       <= '0;
            len_q       <= '0;
            limit_q     <= '0;
            hist_q      <= '0;
            fill_q      <= '0;
            bit_cnt_q   <= '0;
            match_cnt_q <= '0;
            pattern_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            loaded_q    <= loaded_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            limit_q     <= limit_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            bit_cnt_q   <= bit_cnt_d;
            match_cnt_q <= match_cnt_d;
            pattern_q   <= pattern_d;
            cfg_err_q   <= cfg_err_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.pattern       = pattern_q;
    assign bus.match_count_o = match_cnt_q;
    assign bus.cfg_ready_o   = cfg_ready_q;
    assign bus.cfg_err_o     = cfg_err_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Scoreboard bench for pattern_det_ctrl: stimulus pushes expected output
// events (match pulse, done pulse, config error) and a negedge monitor pops
// and compares them as the detectors present them. Two instances cover the
// overlapping and non-overlapping modes.
module tb_pattern_det_ctrl;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 16;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    localparam logic [1:0] EV_PAT  = 2'd0;
    localparam logic [1:0] EV_DONE = 2'd1;
    localparam logic [1:0] EV_ERR  = 2'd2;

    typedef struct packed {
        logic [1:0]       kind;
        logic [CNT_W-1:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // shared stimulus, steered to one instance by sel
    logic               sel       = 1'b0;
    logic               cfg_valid = 1'b0;
    logic [MAX_LEN-1:0] cfg_pat   = '0;
    logic [LEN_W-1:0]   cfg_len   = '0;
    logic [CNT_W-1:0]   bit_limit = '0;
    logic               start     = 1'b0;
    logic               stop      = 1'b0;
    logic               d         = 1'b0;
    logic               vld       = 1'b0;

    pattern_det_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) if0 ();
    pattern_det_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) if1 ();

    assign if0.cfg_valid_i = cfg_valid & ~sel;
    assign if0.cfg_pat_i   = cfg_pat;
    assign if0.cfg_len_i   = cfg_len;
    assign if0.bit_limit_i = bit_limit;
    assign if0.start_i     = start & ~sel;
    assign if0.stop_i      = stop & ~sel;
    assign if0.d_in        = d;
    assign if0.valid_i     = vld & ~sel;

    assign if1.cfg_valid_i = cfg_valid & sel;
    assign if1.cfg_pat_i   = cfg_pat;
    assign if1.cfg_len_i   = cfg_len;
    assign if1.bit_limit_i = bit_limit;
    assign if1.start_i     = start & sel;
    assign if1.stop_i      = stop & sel;
    assign if1.d_in        = d;
    assign if1.valid_i     = vld & sel;

    pattern_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .OVERLAP(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    pattern_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .OVERLAP(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    int  total  = 0;
    int  passed = 0;
    ev_t q0[$];
    ev_t q1[$];
    int  pulses0 = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic expect_ev(input int which, input logic [1:0] kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = CNT_W'(val);
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endtask

    // Pop the oldest expected event for an instance and compare it.
    task automatic scb(input int which, input logic [1:0] kind, input logic [CNT_W-1:0] cnt);
        ev_t e;
        if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
            total++;
            $display("FAIL dut%0d unexpected event: got kind %0d count %0d, expected none",
                     which, kind, cnt);
            return;
        end
        if (which == 0) e = q0.pop_front();
        else            e = q1.pop_front();
        check($sformatf("dut%0d event kind", which), kind, e.kind);
        if (kind != EV_ERR) check($sformatf("dut%0d count at event", which), cnt, e.val);
    endtask

    // Monitor: outputs are sampled on the falling edge, away from updates.
    always @(negedge clk) begin
        if (!rst) begin
            if (if0.cfg_err_o) scb(0, EV_ERR, if0.match_count_o);
            if (if0.pattern) begin
                pulses0++;
                scb(0, EV_PAT, if0.match_count_o);
            end
            if (if0.done_o) scb(0, EV_DONE, if0.match_count_o);
            if (if1.cfg_err_o) scb(1, EV_ERR, if1.match_count_o);
            if (if1.pattern)   scb(1, EV_PAT, if1.match_count_o);
            if (if1.done_o)    scb(1, EV_DONE, if1.match_count_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l);
        cfg_pat   = p;
        cfg_len   = l;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic run_start(input logic [CNT_W-1:0] lim);
        bit_limit = lim;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        d   = b;
        vld = 1'b1;
        tick();
        vld = 1'b0;
    endtask

    task automatic send_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin : stim
        logic [6:0] s7;
        logic [7:0] s8;
        logic [2:0] mh;
        int         mn;
        int         mcnt;
        int         nbits;
        int         p_before;

        // reset state
        tick();
        check("reset cfg_ready", if0.cfg_ready_o, 1);
        check("reset busy", if0.busy_o, 0);
        check("reset done", if0.done_o, 0);
        check("reset pattern", if0.pattern, 0);
        check("reset count", if0.match_count_o, 0);
        check("reset cfg_err", if0.cfg_err_o, 0);
        rst = 1'b0;
        tick();

        // start with nothing loaded is ignored
        run_start(16'd0);
        check("start unloaded busy", if0.busy_o, 0);

        // illegal lengths: error pulse, still unloaded
        expect_ev(0, EV_ERR, 0);
        cfg_write(8'b0000_1011, 4'd0);
        tick();
        run_start(16'd0);
        check("start after len0 busy", if0.busy_o, 0);
        expect_ev(0, EV_ERR, 0);
        cfg_write(8'b0000_1011, 4'd9);
        tick();
        run_start(16'd0);
        check("start after len9 busy", if0.busy_o, 0);

        // overlapping run: 1011 len 4, bits 1,0,1,1,0,1,1
        cfg_write(8'b0000_1011, 4'd4);
        run_start(16'd0);
        check("armed busy", if0.busy_o, 1);
        check("armed cfg_ready", if0.cfg_ready_o, 0);
        check("armed count cleared", if0.match_count_o, 0);
        cfg_write(8'b0000_1111, 4'd4);   // ignored while armed
        cfg_write(8'b0000_1111, 4'd0);   // ignored, no error pulse
        s7 = 7'b1011011;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) expect_ev(0, EV_PAT, 1);
            if (i == 6) expect_ev(0, EV_PAT, 2);
            send_bit(s7[6-i]);
            if (i == 4) begin
                tick();                  // gap with valid low
                tick();
            end
        end
        expect_ev(0, EV_DONE, 2);
        send_stop();
        tick();
        check("overlap count held in idle", if0.match_count_o, 2);
        check("idle busy", if0.busy_o, 0);
        check("idle cfg_ready", if0.cfg_ready_o, 1);

        // non-overlapping instance, same stream
        sel = 1'b1;
        cfg_write(8'b0000_1011, 4'd4);
        run_start(16'd0);
        check("dut1 armed busy", if1.busy_o, 1);
        for (int i = 0; i < 7; i++) begin
            if (i == 3) expect_ev(1, EV_PAT, 1);
            send_bit(s7[6-i]);
        end
        expect_ev(1, EV_DONE, 1);
        send_stop();
        tick();
        check("nonoverlap count", if1.match_count_o, 1);
        sel = 1'b0;

        // bit limit 5: stream 1,0,1,1,1,0,1,1 (config still 1011)
        run_start(16'd5);
        s8 = 8'b10111011;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) expect_ev(0, EV_PAT, 1);
            if (i == 4) expect_ev(0, EV_DONE, 1);
            send_bit(s8[7-i]);
        end
        tick();
        check("limit count", if0.match_count_o, 1);
        check("limit back to idle", if0.busy_o, 0);

        // stop together with the completing bit
        run_start(16'd0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        expect_ev(0, EV_PAT, 1);
        expect_ev(0, EV_DONE, 1);
        d    = 1'b1;
        vld  = 1'b1;
        stop = 1'b1;
        tick();
        vld  = 1'b0;
        stop = 1'b0;
        tick();
        check("stop+bit count", if0.match_count_o, 1);

        // random stream, pattern 101 len 3, compared with a simple model
        cfg_write(8'b0000_0101, 4'd3);
        run_start(16'd0);
        p_before = pulses0;
        mh = '0; mn = 0; mcnt = 0; nbits = 0;
        while (nbits < 1000) begin
            if ($urandom_range(0, 3) != 0) begin
                d  = 1'($urandom_range(0, 1));
                mh = {mh[1:0], d};
                mn++;
                nbits++;
                if (mn >= 3 && mh == 3'b101) begin
                    mcnt++;
                    expect_ev(0, EV_PAT, mcnt);
                end
                vld = 1'b1;
            end else begin
                vld = 1'b0;
            end
            tick();
        end
        vld = 1'b0;
        expect_ev(0, EV_DONE, mcnt);
        send_stop();
        tick();
        check("random count", if0.match_count_o, mcnt);
        check("random pulses", pulses0 - p_before, mcnt);

        // reset in the middle of a run after 10 bits
        run_start(16'd0);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) expect_ev(0, EV_PAT, 1);
            send_bit((i == 0 || i == 2) ? 1'b1 : 1'b0);
        end
        check("pre-reset count", if0.match_count_o, 1);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", if0.busy_o, 0);
        check("async rst count", if0.match_count_o, 0);
        check("async rst pattern", if0.pattern, 0);
        check("async rst done", if0.done_o, 0);
        check("async rst cfg_ready", if0.cfg_ready_o, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        run_start(16'd0);
        check("start after reset busy", if0.busy_o, 0);
        tick();

        check("dut0 queue drained", q0.size(), 0);
        check("dut1 queue drained", q1.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
